// File: rtl/extern_iter_sequencer_if.sv
// Handshake and extern-call bundle for extern_iter_sequencer.
// The master modport is the sequencer side. The slave modport is the
// environment: the seed producer, the result consumer and the extern instance.
interface extern_iter_sequencer_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int ITER_W = 4,
  parameter int CNT_W  = 16
);
  logic              seed_valid;
  logic              seed_ready;
  logic [IN_W-1:0]   seed;
  logic [ITER_W-1:0] iters;
  logic [IN_W-1:0]   ext_x;
  logic              ext_req;
  logic [OUT_W-1:0]  ext_out;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic [CNT_W-1:0]  call_count;

  modport master (
    input  seed_valid, seed, iters, ext_out, out_ready,
    output seed_ready, ext_x, ext_req, out_valid, out_data, busy, call_count
  );

  modport slave (
    output seed_valid, seed, iters, ext_out, out_ready,
    input  seed_ready, ext_x, ext_req, out_valid, out_data, busy, call_count
  );
endinterface

// File: rtl/extern_iter_sequencer.sv
// Iterating extern-call sequencer. A seed is sent to an external function.
// The block waits EXT_LAT cycles, then feeds the zero-extended result back
// as the next argument. This repeats for a run-time number of iterations,
// and the last result is presented on a valid/ready output.
// The extern result is sampled exactly EXT_LAT cycles after the call strobe.
// Interface widths must match the module parameters. OUT_W <= IN_W and
// EXT_LAT >= 1 are required.
module extern_iter_sequencer #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int EXT_LAT = 1,
  parameter int ITER_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  extern_iter_sequencer_if.master bus
);

  localparam int LAT_W = (EXT_LAT > 1) ? $clog2(EXT_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(EXT_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IN_W-1:0]   r_state_reg;
  logic [IN_W-1:0]   r_ext_x;
  logic [ITER_W-1:0] r_remaining;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [OUT_W-1:0]  r_out_data;
  logic [CNT_W-1:0]  r_call_count;
  logic [IN_W-1:0]   w_feedback;
  logic              w_sample;
  logic              w_last;

  // The counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Zero-extend the extern result. Nothing is lost because OUT_W <= IN_W.
  assign w_feedback = IN_W'(bus.ext_out);
  assign w_sample   = (r_state == S_WAIT) && (r_lat_cnt == '0);
  assign w_last     = (r_remaining == ITER_W'(1));

  // State register; reset aborts any state, including WAIT and EMIT.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.seed_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_sample) w_state_nxt = w_last ? S_EMIT : S_ISSUE;
      S_EMIT:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: seed capture, latency countdown, result feedback and call count.
  // r_ext_x is a separate copy of the argument so that ext_x keeps the last
  // issued argument in EMIT/IDLE, while r_state_reg already holds the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_reg  <= '0;
      r_ext_x      <= '0;
      r_remaining  <= '0;
      r_lat_cnt    <= '0;
      r_out_data   <= '0;
      r_call_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.seed_valid) begin
            r_state_reg <= bus.seed;
            r_ext_x     <= bus.seed;
            r_remaining <= (bus.iters == '0) ? ITER_W'(1) : bus.iters;
          end
        end
        S_ISSUE: begin
          r_lat_cnt    <= LAT_RELOAD;
          r_call_count <= sat_inc(r_call_count);
        end
        S_WAIT: begin
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end else begin
            r_state_reg <= w_feedback;
            r_out_data  <= bus.ext_out;
            r_remaining <= r_remaining - ITER_W'(1);
            if (!w_last) r_ext_x <= w_feedback;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.seed_ready = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_EMIT);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.ext_req    = (r_state == S_ISSUE);
  assign bus.ext_x      = r_ext_x;
  assign bus.out_data   = r_out_data;
  assign bus.call_count = r_call_count;

endmodule

// File: tb/tb_extern_iter_sequencer.sv
// Directed bench for extern_iter_sequencer. It has three instances:
//   A: EXT_LAT=1, CNT_W=16
//   B: EXT_LAT=3
//   C: CNT_W=2 (saturation)
// Each instance talks to an extern model that returns x[7:0]+1 exactly
// EXT_LAT cycles after ext_req. The model shows 8'hEE at other times.
// "cycle 0" is the cycle in which seed_valid is presented and accepted.
module tb_extern_iter_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  extern_iter_sequencer_if #(.IN_W(16), .OUT_W(8), .ITER_W(4), .CNT_W(16)) ia();
  extern_iter_sequencer_if #(.IN_W(16), .OUT_W(8), .ITER_W(4), .CNT_W(16)) ib();
  extern_iter_sequencer_if #(.IN_W(16), .OUT_W(8), .ITER_W(4), .CNT_W(2))  ic();

  extern_iter_sequencer #(.IN_W(16), .OUT_W(8), .EXT_LAT(1), .ITER_W(4), .CNT_W(16))
    u_a (.clk(clk), .rst(rst), .bus(ia.master));
  extern_iter_sequencer #(.IN_W(16), .OUT_W(8), .EXT_LAT(3), .ITER_W(4), .CNT_W(16))
    u_b (.clk(clk), .rst(rst), .bus(ib.master));
  extern_iter_sequencer #(.IN_W(16), .OUT_W(8), .EXT_LAT(1), .ITER_W(4), .CNT_W(2))
    u_c (.clk(clk), .rst(rst), .bus(ic.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Extern models
  logic [7:0] b_p1, b_p2;
  always @(posedge clk) ia.ext_out <= ia.ext_req ? ia.ext_x[7:0] + 8'd1 : 8'hEE;
  always @(posedge clk) ic.ext_out <= ic.ext_req ? ic.ext_x[7:0] + 8'd1 : 8'hEE;
  always @(posedge clk) begin
    b_p1      <= ib.ext_req ? ib.ext_x[7:0] + 8'd1 : 8'hEE;
    b_p2      <= b_p1;
    ib.ext_out <= b_p2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ia.seed_valid = 0; ia.seed = '0; ia.iters = '0; ia.out_ready = 0;
    ib.seed_valid = 0; ib.seed = '0; ib.iters = '0; ib.out_ready = 0;
    ic.seed_valid = 0; ic.seed = '0; ic.iters = '0; ic.out_ready = 0;
    step(); step();

    // Reset state
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_ext_req", ia.ext_req, 0);
    chk("rst_ext_x", ia.ext_x, 0);
    chk("rst_out_data", ia.out_data, 0);
    chk("rst_call_count", ia.call_count, 0);
    chk("rst_busy", ia.busy, 0);
    rst = 1'b1;
    step();
    chk("rel_seed_ready", ia.seed_ready, 1);

    // Test 1: seed 0x1234, iters=1
    ia.seed = 16'h1234; ia.iters = 4'd1; ia.seed_valid = 1;      // cycle 0
    step();                                                       // cycle 1
    ia.seed_valid = 0; ia.seed = 16'hFFFF; ia.iters = 4'd7;
    chk("t1_req_c1", ia.ext_req, 1);
    chk("t1_x_c1", ia.ext_x, 16'h1234);
    chk("t1_busy_c1", ia.busy, 1);
    chk("t1_sready_c1", ia.seed_ready, 0);
    step();                                                       // cycle 2
    chk("t1_req_c2", ia.ext_req, 0);
    chk("t1_x_c2", ia.ext_x, 16'h1234);
    chk("t1_ovalid_c2", ia.out_valid, 0);
    step();                                                       // cycle 3
    chk("t1_ovalid_c3", ia.out_valid, 1);
    chk("t1_odata_c3", ia.out_data, 8'h35);
    chk("t1_count", ia.call_count, 1);
    chk("t1_x_emit", ia.ext_x, 16'h1234);
    ia.out_ready = 1;
    step();                                                       // cycle 4
    ia.out_ready = 0;
    chk("t1_ovalid_c4", ia.out_valid, 0);
    chk("t1_sready_c4", ia.seed_ready, 1);

    // Test 2: seed 0x00FE, iters=3, then backpressure in EMIT (test 5)
    ia.seed = 16'h00FE; ia.iters = 4'd3; ia.seed_valid = 1;      // cycle 0
    step(); ia.seed_valid = 0;                                    // cycle 1
    chk("t2_req_c1", ia.ext_req, 1);
    chk("t2_x_c1", ia.ext_x, 16'h00FE);
    step();                                                       // cycle 2
    chk("t2_req_c2", ia.ext_req, 0);
    step();                                                       // cycle 3
    chk("t2_req_c3", ia.ext_req, 1);
    chk("t2_x_c3", ia.ext_x, 16'h00FF);
    step(); step();                                               // cycle 5
    chk("t2_req_c5", ia.ext_req, 1);
    chk("t2_x_c5", ia.ext_x, 16'h0000);
    step();                                                       // cycle 6
    chk("t2_ovalid_c6", ia.out_valid, 0);
    step();                                                       // cycle 7
    chk("t2_ovalid_c7", ia.out_valid, 1);
    chk("t2_odata", ia.out_data, 8'h01);
    chk("t2_count", ia.call_count, 4);   // 1 from test 1 + 3
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_hold_ovalid", ia.out_valid, 1);
      chk("t5_hold_odata", ia.out_data, 8'h01);
      chk("t5_hold_sready", ia.seed_ready, 0);
    end
    ia.out_ready = 1;
    step();
    ia.out_ready = 0;
    chk("t5_ovalid_after", ia.out_valid, 0);
    chk("t5_sready_after", ia.seed_ready, 1);
    chk("t5_busy_after", ia.busy, 0);

    // Test 3: iters=0 treated as 1
    ia.seed = 16'h0010; ia.iters = 4'd0; ia.seed_valid = 1;
    step(); ia.seed_valid = 0;
    chk("t3_req_c1", ia.ext_req, 1);
    chk("t3_x_c1", ia.ext_x, 16'h0010);
    step();
    chk("t3_req_c2", ia.ext_req, 0);
    step();
    chk("t3_req_c3", ia.ext_req, 0);
    chk("t3_ovalid", ia.out_valid, 1);
    chk("t3_odata", ia.out_data, 8'h11);
    chk("t3_count", ia.call_count, 5);
    ia.out_ready = 1;
    step();
    ia.out_ready = 0;

    // Test 4: EXT_LAT=3, iters=2
    ib.seed = 16'h0040; ib.iters = 4'd2; ib.seed_valid = 1;      // cycle 0
    step(); ib.seed_valid = 0;                                    // cycle 1
    chk("t4_req_c1", ib.ext_req, 1);
    chk("t4_x_c1", ib.ext_x, 16'h0040);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("t4_req_wait1", ib.ext_req, 0);
      chk("t4_x_wait1", ib.ext_x, 16'h0040);
    end
    step();                                                       // cycle 5
    chk("t4_req_c5", ib.ext_req, 1);
    chk("t4_x_c5", ib.ext_x, 16'h0041);
    step(); step(); step();                                       // cycle 8
    chk("t4_ovalid_c8", ib.out_valid, 0);
    step();                                                       // cycle 9
    chk("t4_ovalid_c9", ib.out_valid, 1);
    chk("t4_odata", ib.out_data, 8'h42);
    chk("t4_count", ib.call_count, 2);
    ib.out_ready = 1;
    step();
    ib.out_ready = 0;

    // Test 6: reset during WAIT of iteration 2
    ia.seed = 16'h0020; ia.iters = 4'd3; ia.seed_valid = 1;      // cycle 0
    step(); ia.seed_valid = 0;                                    // cycle 1 ISSUE
    step(); step(); step();                                       // cycle 4 WAIT (iter 2)
    chk("t6_pre_busy", ia.busy, 1);
    chk("t6_pre_req", ia.ext_req, 0);
    rst = 1'b0;
    step();                                                       // cycle 5
    rst = 1'b1;
    chk("t6_busy", ia.busy, 0);
    chk("t6_ovalid", ia.out_valid, 0);
    chk("t6_count", ia.call_count, 0);
    chk("t6_req", ia.ext_req, 0);
    chk("t6_x", ia.ext_x, 0);
    step();
    chk("t6_req_after", ia.ext_req, 0);
    chk("t6_sready_after", ia.seed_ready, 1);
    ia.seed = 16'h0005; ia.iters = 4'd1; ia.seed_valid = 1;
    step(); ia.seed_valid = 0;
    chk("t6_new_req", ia.ext_req, 1);
    chk("t6_new_x", ia.ext_x, 16'h0005);
    step(); step();
    chk("t6_new_ovalid", ia.out_valid, 1);
    chk("t6_new_odata", ia.out_data, 8'h06);
    chk("t6_new_count", ia.call_count, 1);
    ia.out_ready = 1;
    step();
    ia.out_ready = 0;

    // Test 7: saturating 2-bit call counter
    for (int i = 0; i < 5; i++) begin
      ic.seed = 16'(16'h0030 + i); ic.iters = 4'd1; ic.seed_valid = 1;
      step(); ic.seed_valid = 0;
      step(); step();
      chk("t7_ovalid", ic.out_valid, 1);
      chk("t7_odata", ic.out_data, 32'(8'h31 + i));
      chk("t7_count", ic.call_count, (i < 3) ? i + 1 : 3);
      ic.out_ready = 1;
      step();
      ic.out_ready = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
